bluetooth_decoder: RTL and testbench
====================================

Name: bluetooth_decoder

Overview:
- Receive-side counterpart of the Bluefruit AT command encoder. It parses the byte stream returned by the BLE UART module after an AT+BLEUARTTX=/AT+BLEUARTRX command.
- Extracts up to 4 payload bytes and the final status line ("OK" or "ERROR"), then reports the result with a one-cycle done pulse.
- Sits between the UART receiver (byte/valid stream) and the command controller that issues start.

Parameters:
- MAX_PAYLOAD, 4, payload bytes captured into output_data (fixed 4 for the 32-bit port).
- TIMEOUT_CYCLES, 1000000, idle clk cycles without rx_valid before abort (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets).
- start  input  1  arm decode of one response; sampled in IDLE only.
- expect_data  input  1  sampled with start; 1 = RX response (payload line expected), 0 = TX ack only.
- rx_byte  input  8  byte from UART receiver.
- rx_valid  input  1  rx_byte valid this cycle; no backpressure.
- output_data  output  32  payload; first received byte in [7:0], second in [15:8], and so on; unfilled bytes 0.
- data_len  output  3  payload bytes captured, 0..4.
- resp_ok  output  1  status line was "OK".
- resp_error  output  1  status line was "ERROR", or a protocol error occurred.
- overflow  output  1  payload line exceeded 4 bytes, or an extra data line arrived.
- timeout  output  1  decode aborted on timeout (tied 0 without the feature).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; all outputs and internal registers 0.
- Flow IDLE -> COLLECT -> DONE -> IDLE.
- IDLE: on start=1, clear output_data, data_len, all flags, and the line buffer; latch expect_data; next cycle enters COLLECT with busy=1. rx_valid in IDLE is dropped.
- COLLECT accepts one byte per rx_valid cycle:
  - 0x0A (LF) is ignored.
  - Any non-CR byte increments line_cnt (saturating at 7). If line_cnt<4, the byte goes into the line buffer at byte line_cnt.
  - Two running matchers compare the line against "OK" and "ERROR" position by position.
  - 0x0D (CR) with line_cnt=0 (empty line) is ignored.
  - CR with line_cnt>0 classifies the line and then resets line_cnt and the matchers:
    - "OK" (exactly 2 chars, matched): resp_ok=1, go to DONE.
    - "ERROR" (exactly 5 chars, matched): resp_error=1, go to DONE.
    - Any other line is a data line:
      - expect_data=1 and no data line captured yet: output_data <= buffer, data_len <= min(line_cnt,4); overflow=1 if line_cnt>4.
      - Otherwise (expect_data=0, or a second data line): line discarded, overflow=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
  - Latency: done is high on the cycle after the terminating CR is sampled.
  - Result outputs hold until the next accepted start.
- start while busy: ignored.
- rx_valid in DONE: byte dropped.
- Empty RX response ("OK\r\n" only): data_len=0, output_data=0, resp_ok=1.
- Reset asserted mid-decode: immediate abort to IDLE with outputs cleared; no done pulse.

Optional Feature:
- Macro: BT_DECODER_TIMEOUT_EN.
- When defined:
  - A 32-bit idle counter runs in COLLECT. It reloads on each rx_valid and on entry to COLLECT.
  - When the counter reaches TIMEOUT_CYCLES: timeout=1, resp_error=1, go to DONE.
  - rx_valid in the same cycle as expiry wins; the byte is processed and the counter reloads.
- When undefined: no counter is built, timeout is tied 0, and the block waits indefinitely for a status line.

Decomposition:
- Shared package bt_pkg:
  - ASCII constants: A–Z, '+', '=', CR 8'h0D, LF 8'h0A. The encoder migrates to these.
  - Decoder state enum: IDLE, COLLECT, DONE.
- Sub-module bluetooth_line_collector: LF skip, line buffer, line_cnt, and OK/ERROR matchers. It emits a line_end strobe with a classification (empty/ok/error/data), a byte count, and the buffer. The top level holds the FSM, result registers and the timeout.

Test Plan:
- start with expect_data=1; bytes "WXYZ\r\nOK\r\n" -> done after final CR; output_data=32'h5A595857, data_len=4, resp_ok=1, overflow=0.
- start with expect_data=1; bytes "OK\r\n" -> output_data=0, data_len=0, resp_ok=1.
- start with expect_data=0; bytes "ERROR\r\n" -> resp_error=1, resp_ok=0, data_len=0; done exactly one cycle.
- start with expect_data=1; bytes "ABCDEF\r\nOK\r\n" -> output_data=32'h44434241, data_len=4, overflow=1, resp_ok=1.
- start with expect_data=1; bytes "AB", then reset low for 1 cycle -> all outputs 0, no done; second start during busy -> ignored.
- With BT_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, then no bytes -> done 16 cycles after entering COLLECT; timeout=1, resp_error=1.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluefruit AT command encoder/decoder pair:
// ASCII constants, decoder FSM states and line classifications.
package bt_pkg;

  localparam logic [7:0] ASCII_A = 8'h41, ASCII_B = 8'h42, ASCII_C = 8'h43, ASCII_D = 8'h44;
  localparam logic [7:0] ASCII_E = 8'h45, ASCII_F = 8'h46, ASCII_G = 8'h47, ASCII_H = 8'h48;
  localparam logic [7:0] ASCII_I = 8'h49, ASCII_J = 8'h4A, ASCII_K = 8'h4B, ASCII_L = 8'h4C;
  localparam logic [7:0] ASCII_M = 8'h4D, ASCII_N = 8'h4E, ASCII_O = 8'h4F, ASCII_P = 8'h50;
  localparam logic [7:0] ASCII_Q = 8'h51, ASCII_R = 8'h52, ASCII_S = 8'h53, ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_U = 8'h55, ASCII_V = 8'h56, ASCII_W = 8'h57, ASCII_X = 8'h58;
  localparam logic [7:0] ASCII_Y = 8'h59, ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_EQUAL = 8'h3D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int LINE_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } dec_state_e;

  typedef enum logic [1:0] {
    LINE_EMPTY = 2'd0,
    LINE_OK    = 2'd1,
    LINE_ERROR = 2'd2,
    LINE_DATA  = 2'd3
  } line_class_e;

  function automatic logic [7:0] ok_char(input logic [2:0] idx);
    case (idx)
      3'd0:    ok_char = ASCII_O;
      3'd1:    ok_char = ASCII_K;
      default: ok_char = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] error_char(input logic [2:0] idx);
    case (idx)
      3'd0:    error_char = ASCII_E;
      3'd1:    error_char = ASCII_R;
      3'd2:    error_char = ASCII_R;
      3'd3:    error_char = ASCII_O;
      3'd4:    error_char = ASCII_R;
      default: error_char = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bluetooth_line_collector.sv
// Splits the UART byte stream into CR-terminated lines: skips LF, buffers the
// first four bytes, counts line length and tracks the "OK"/"ERROR" matchers.
module bluetooth_line_collector
  import bt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        line_end,
  output logic [1:0]  line_class,
  output logic [2:0]  line_len,
  output logic [31:0] line_buf
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  // Mismatch flags rather than match flags, so the idle/reset value of 0 means
  // "still matching".
  logic        ok_miss_q, ok_miss_d;
  logic        err_miss_q, err_miss_d;

  logic take, is_cr, is_lf;

  assign take  = enable && rx_valid;
  assign is_cr = (rx_byte == ASCII_CR);
  assign is_lf = (rx_byte == ASCII_LF);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    ok_miss_d  = ok_miss_q;
    err_miss_d = err_miss_q;
    line_end   = 1'b0;
    line_class = LINE_EMPTY;
    if (clear) begin
      cnt_d      = '0;
      buf_d      = '0;
      ok_miss_d  = 1'b0;
      err_miss_d = 1'b0;
    end else if (take && !is_lf) begin
      if (is_cr) begin
        if (cnt_q != 3'd0) begin
          line_end = 1'b1;
          if (!ok_miss_q && cnt_q == 3'd2)
            line_class = LINE_OK;
          else if (!err_miss_q && cnt_q == 3'd5)
            line_class = LINE_ERROR;
          else
            line_class = LINE_DATA;
          cnt_d      = '0;
          buf_d      = '0;
          ok_miss_d  = 1'b0;
          err_miss_d = 1'b0;
        end
      end else begin
        if (cnt_q != 3'd7)
          cnt_d = cnt_q + 3'd1;
        for (int i = 0; i < LINE_BYTES; i++) begin
          if (cnt_q == 3'(i))
            buf_d[i*8 +: 8] = rx_byte;
        end
        ok_miss_d  = ok_miss_q  || (cnt_q >= 3'd2) || (rx_byte != ok_char(cnt_q));
        err_miss_d = err_miss_q || (cnt_q >= 3'd5) || (rx_byte != error_char(cnt_q));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      ok_miss_q  <= 1'b0;
      err_miss_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      ok_miss_q  <= ok_miss_d;
      err_miss_q <= err_miss_d;
    end
  end

  assign line_len = cnt_q;
  assign line_buf = buf_q;

endmodule

// File: rtl/bluetooth_decoder.sv
// Decodes one BLE UART response (payload line plus OK/ERROR status) per start.
// Optional idle timeout is built when BT_DECODER_TIMEOUT_EN is defined.
module bluetooth_decoder
  import bt_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        expect_data,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] output_data,
  output logic [2:0]  data_len,
  output logic        resp_ok,
  output logic        resp_error,
  output logic        overflow,
  output logic        timeout,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_PAYLOAD);

  dec_state_e  state_q, state_d;
  logic        expect_q, expect_d;
  logic        seen_q, seen_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  len_q, len_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;

  logic        accept;
  logic        line_end;
  logic [1:0]  line_class;
  logic [2:0]  line_len;
  logic [31:0] line_buf;

  assign accept = (state_q == ST_IDLE) && start;

  bluetooth_line_collector u_collector (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept),
    .enable     (state_q == ST_COLLECT),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .line_end   (line_end),
    .line_class (line_class),
    .line_len   (line_len),
    .line_buf   (line_buf)
  );

  logic idle_expired;
`ifdef BT_DECODER_TIMEOUT_EN
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // A byte arriving in the expiry cycle wins: it reloads instead of expiring.
  assign idle_expired = (state_q == ST_COLLECT) && !rx_valid && (idle_cnt_q == IDLE_LAST);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (accept)
      idle_cnt_d = '0;
    else if (state_q == ST_COLLECT)
      idle_cnt_d = rx_valid ? '0 : idle_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign idle_expired = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    seen_d   = seen_q;
    data_d   = data_q;
    len_d    = len_q;
    ok_d     = ok_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_COLLECT;
          expect_d = expect_data;
          seen_d   = 1'b0;
          data_d   = '0;
          len_d    = '0;
          ok_d     = 1'b0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (line_end) begin
          if (line_class == LINE_OK) begin
            ok_d    = 1'b1;
            state_d = ST_DONE;
          end else if (line_class == LINE_ERROR) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (expect_q && !seen_q) begin
            seen_d = 1'b1;
            data_d = line_buf;
            len_d  = (line_len > MAX_LEN) ? MAX_LEN : line_len;
            ovf_d  = ovf_q || (line_len > MAX_LEN);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (idle_expired) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is asynchronous and active-low; every register, including the
  // result holding registers, returns to 0 so an aborted decode leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      expect_q <= 1'b0;
      seen_q   <= 1'b0;
      data_q   <= '0;
      len_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
      seen_q   <= seen_d;
      data_q   <= data_d;
      len_q    <= len_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  assign output_data = data_q;
  assign data_len    = len_q;
  assign resp_ok     = ok_q;
  assign resp_error  = err_q;
  assign overflow    = ovf_q;
  assign timeout     = tmo_q;
  assign busy        = (state_q == ST_COLLECT);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_bluetooth_decoder.sv
// Scoreboard bench for bluetooth_decoder: expected results are queued when a
// response is driven and compared when done pulses.
module tb_bluetooth_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        expect_data = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] output_data;
  logic [2:0]  data_len;
  logic        resp_ok, resp_error, overflow, timeout, busy, done;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
    logic        ok;
    logic        err;
    logic        ovf;
    logic        tmo;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  bluetooth_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .expect_data (expect_data),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .output_data (output_data),
    .data_len    (data_len),
    .resp_ok     (resp_ok),
    .resp_error  (resp_error),
    .overflow    (overflow),
    .timeout     (timeout),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compares results against the scoreboard on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_pulse_width", {31'd0, done}, 32'd0);
    if (done) begin
      done_cnt++;
      check("busy_at_done", {31'd0, busy}, 32'd0);
      check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("output_data", output_data, e.data);
        check("data_len", {29'd0, data_len}, {29'd0, e.len});
        check("resp_ok", {31'd0, resp_ok}, {31'd0, e.ok});
        check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        check("timeout", {31'd0, timeout}, {31'd0, e.tmo});
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input logic [31:0] d, input logic [2:0] l,
                          input logic ok, input logic err, input logic ovf, input logic tmo);
    exp_t e;
    e.data = d; e.len = l; e.ok = ok; e.err = err; e.ovf = ovf; e.tmo = tmo;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string s);
    send_str(s);
    send_byte(CR);
    send_byte(LF);
  endtask

  task automatic do_start(input logic ed);
    start       = 1'b1;
    expect_data = ed;
    tick();
    start       = 1'b0;
    expect_data = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0);
    int i = 0;
    while (done_cnt == n0 && i < 64) begin
      @(negedge clk);
      #1;
      i++;
    end
    check({tag, "_done_seen"}, {31'd0, done_cnt != n0}, 32'd1);
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    check("rst_output_data", output_data, 32'd0);
    check("rst_flags", {24'd0, data_len, resp_ok, resp_error, overflow, timeout, busy},
          32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    tick();

    // Bytes in IDLE are dropped.
    send_str("ZZ");
    send_byte(CR);

    // Full RX response: four payload bytes then OK; latency checked directly.
    n0 = done_cnt;
    push_exp(32'h5A595857, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    do_start(1'b1);
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    send_line("WXYZ");
    send_str("OK");
    send_byte(CR);
    check("t1_done_after_cr", {31'd0, done}, 32'd1);
    send_byte(LF);
    wait_done("t1", n0);
    repeat (3) tick();
    check("t1_hold_data", output_data, 32'h5A595857);
    check("t1_hold_ok", {31'd0, resp_ok}, 32'd1);

    // Empty RX response.
    n0 = done_cnt;
    push_exp(32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_start(1'b1);
    send_line("OK");
    wait_done("t2", n0);

    // TX ack that reports ERROR.
    n0 = done_cnt;
    push_exp(32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_start(1'b0);
    send_line("ERROR");
    wait_done("t3", n0);

    // Payload longer than four bytes.
    n0 = done_cnt;
    push_exp(32'h44434241, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    do_start(1'b1);
    send_line("ABCDEF");
    send_line("OK");
    wait_done("t4", n0);

    // Data line when none is expected.
    n0 = done_cnt;
    push_exp(32'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_start(1'b0);
    send_line("HI");
    send_line("OK");
    wait_done("t5", n0);

    // Second data line is discarded; start while busy is ignored.
    n0 = done_cnt;
    push_exp(32'h00004241, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    do_start(1'b1);
    send_str("AB");
    do_start(1'b0);
    send_byte(CR);
    send_byte(LF);
    send_line("CD");
    send_line("OK");
    wait_done("t6", n0);

    // Empty lines skipped; a near-miss "OKK" is data; then ERROR.
    n0 = done_cnt;
    push_exp(32'h004B4B4F, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    do_start(1'b1);
    send_byte(CR);
    send_byte(LF);
    send_byte(CR);
    send_line("OKK");
    send_line("ERROR");
    wait_done("t7", n0);

    // Reset mid-decode: immediate abort, outputs cleared, no done.
    n0 = done_cnt;
    do_start(1'b1);
    send_line("AB");
    send_str("OK");
    reset = 1'b0;
    @(negedge clk);
    check("abort_output_data", output_data, 32'd0);
    check("abort_flags", {24'd0, data_len, resp_ok, resp_error, overflow, timeout, busy},
          32'd0);
    tick();
    reset = 1'b1;
    send_byte(CR);
    repeat (10) tick();
    check("abort_no_done", done_cnt, n0);
    check("abort_busy", {31'd0, busy}, 32'd0);

    // Decoder recovers after the abort.
    n0 = done_cnt;
    push_exp(32'h00000051, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_start(1'b1);
    send_line("Q");
    send_line("OK");
    wait_done("t8", n0);

`ifdef BT_DECODER_TIMEOUT_EN
    n0 = done_cnt;
    push_exp(32'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_start(1'b1);
    repeat (15) tick();
    check("to_not_yet", {31'd0, done}, 32'd0);
    tick();
    check("to_done_at_16", {31'd0, done}, 32'd1);
    wait_done("to", n0);
`endif

    repeat (3) tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
